digit_stabilizer: RTL and testbench
===================================

// Module: digit_stabilizer
// PURPOSE
//   Downstream of the 7-input digit classifier. Takes its per-cycle 4-bit
//   prediction (0..9) and commits a digit only after STABLE_CNT consecutive
//   identical valid samples, suppressing glitches from input transitions.
//   Drives the committed digit, its 7-segment pattern, and a one-cycle change
//   pulse, plus a saturating count of out-of-range predictions.
// PARAMETERS
//   STABLE_CNT  4  consecutive matching valid samples needed to commit (1..15)
//   ERR_W       8  width of saturating out-of-range error counter
// PORTS
//   clk         in   1      system clock, all state on rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      in_digit is a fresh classifier result this cycle
//   in_digit    in   4      classifier prediction; legal 0..9
//   out_valid   out  1      a digit has been committed since reset
//   out_digit   out  4      committed digit
//   out_seg     out  7      {g,f,e,d,c,b,a}, active-high; 7'h00 when !out_valid
//   out_change  out  1      1-cycle pulse: committed digit updated this cycle
//   out_run     out  4      current candidate run length (saturates at STABLE_CNT)
//   out_err     out  ERR_W  count of in_valid samples with in_digit>9, saturating
// BEHAVIOUR
//   - Reset (async assert, sync-style release): state=EMPTY, cand=0, run=0,
//     out_valid=0, out_digit=0, out_seg=7'h00, out_change=0, out_err=0.
//   - All outputs are registered; response to a sample is visible the cycle
//     after the edge at which in_valid is sampled high (latency 1).
//   - in_valid=0: hold all state; gaps do not break a run; out_change=0.
//   - States: EMPTY (nothing committed, no candidate), TRACK (candidate run in
//     progress, differs from committed or nothing committed), LOCKED (cand ==
//     committed digit, run saturated).
//   - Valid sample, in_digit>9: out_err += 1 (saturate at all-ones), run=0,
//     state -> EMPTY if !out_valid else LOCKED-with-run-0 treated as TRACK;
//     committed digit/out_seg unchanged; no change pulse.
//   - Valid sample, in_digit<=9, in_digit != cand or run==0: cand=in_digit,
//     run=1; state TRACK (if STABLE_CNT==1 commit immediately, see below).
//   - Valid sample, in_digit == cand, run>0: run = min(run+1, STABLE_CNT).
//   - Commit: when the updated run equals STABLE_CNT and (!out_valid or
//     cand != out_digit): out_digit=cand, out_seg=enc(cand), out_valid=1,
//     out_change=1 for exactly that one cycle; state -> LOCKED.
//   - Run reaching STABLE_CNT with cand == out_digit (flicker back to same
//     digit): state -> LOCKED, no change pulse.
//   - Continued matching samples in LOCKED: run stays saturated, no pulse.
//   - Reset mid-run: everything returns to reset values; partial run lost.
//   - Encoding enc(): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//   - run compare uses unsigned 4-bit arithmetic; STABLE_CNT outside 1..15 is
//     a compile-time error.
// STRUCTURE
//   - Shared package digit_pkg: state encoding (EMPTY/TRACK/LOCKED, 2 bits),
//     SEG_TABLE[0:9] constant, DIGIT_MAX=9.
//   - One sub-module seg7_encode (combinational 4->7 lookup, 7'h00 for >9),
//     instanced ahead of the out_seg register.
//   - Remainder: one state/run/cand always block, one output register block.
// TESTING
//   1. rst pulse mid-cycle -> all outputs zero immediately (async), out_seg=00.
//   2. in_valid=1, in_digit=5 for 4 cycles -> after 4th edge out_digit=5,
//      out_seg=6D, out_valid=1, out_change high exactly 1 cycle, out_run=4.
//   3. 5,5,3,5,5,5 (STABLE_CNT=4) -> no commit; a 4th consecutive 5 commits.
//   4. Locked on 5; send 7,7 then 5,5,5,5 -> no out_change, out_digit stays 5.
//   5. Send 12 with in_valid=1 300 times (ERR_W=8) -> out_err=255, run=0,
//      committed digit unchanged; in_valid=0 gaps inside a 7-run still commit 7.
//   6. STABLE_CNT=1: 2,8,8 -> commit 2 then 8, two pulses, none for second 8.

Source files
------------

// File: rtl/digit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : digit_pkg                                                   |
// | Brief  : Shared state encoding and 7-segment table for the digit     |
// |          stabilizer.                                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package digit_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage : digit_pkg
`default_nettype wire

// File: rtl/digit_stabilizer_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seg7_encode                                                 |
// | Brief  : Combinational 4-bit digit to 7-segment lookup; blank for >9. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seg7_encode
    import digit_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        if (digit_i <= DIGIT_MAX) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule : seg7_encode
`default_nettype wire

// File: rtl/digit_stabilizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : digit_stabilizer                                            |
// | Brief  : Commits a classifier digit after STABLE_CNT consecutive     |
// |          identical valid samples; drives digit, segments, pulse.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module digit_stabilizer
    import digit_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_digit,
    output logic             out_valid,
    output logic [3:0]       out_digit,
    output logic [6:0]       out_seg,
    output logic             out_change,
    output logic [3:0]       out_run,
    output logic [ERR_W-1:0] out_err
);

    generate
        if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable_cnt
            $error("digit_stabilizer: STABLE_CNT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CNT);

    state_e           state_q, state_d;
    logic [3:0]       cand_q,  cand_d;
    logic [3:0]       run_q,   run_d;
    logic             valid_q;
    logic [3:0]       digit_q;
    logic [6:0]       seg_q;
    logic             change_q;
    logic [ERR_W-1:0] err_q;

    logic             commit_w;
    logic             err_inc_w;
    logic [6:0]       seg_w;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        commit_w  = 1'b0;
        err_inc_w = 1'b0;
        if (in_valid) begin
            if (in_digit > DIGIT_MAX) begin
                err_inc_w = 1'b1;
                run_d     = 4'd0;
                state_d   = valid_q ? ST_TRACK : ST_EMPTY;
            end else begin
                if (state_q == ST_EMPTY || run_q == 4'd0 || in_digit != cand_q) begin
                    cand_d  = in_digit;
                    run_d   = 4'd1;
                    state_d = ST_TRACK;
                end else if (state_q != ST_LOCKED && run_q < RUN_MAX) begin
                    run_d = run_q + 4'd1;
                end
                // A run returning to the already-committed digit locks silently.
                if (run_d == RUN_MAX) begin
                    state_d  = ST_LOCKED;
                    commit_w = !valid_q || (cand_d != digit_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cand_q  <= 4'd0;
            run_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
        end
    end

    seg7_encode u_seg7 (
        .digit_i (cand_d),
        .seg_o   (seg_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            digit_q  <= 4'd0;
            seg_q    <= 7'h00;
            change_q <= 1'b0;
            err_q    <= '0;
        end else begin
            change_q <= commit_w;
            if (commit_w) begin
                valid_q <= 1'b1;
                digit_q <= cand_d;
                seg_q   <= seg_w;
            end
            if (err_inc_w && !(&err_q)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_digit  = digit_q;
    assign out_seg    = seg_q;
    assign out_change = change_q;
    assign out_run    = run_q;
    assign out_err    = err_q;

endmodule : digit_stabilizer
`default_nettype wire

// File: tb/tb_digit_stabilizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_digit_stabilizer                                         |
// | Brief  : Directed bench for two stabilizer instances (counts 4, 1).  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_digit_stabilizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_digit = 4'd0;

    logic       ov   [2];
    logic [3:0] od   [2];
    logic [6:0] os   [2];
    logic       och  [2];
    logic [3:0] orun [2];
    logic [7:0] oerr [2];

    int checks   = 0;
    int failures = 0;

    int m_run [2];
    int m_cand[2];
    int m_valid[2];
    int m_digit[2];
    int m_change[2];
    int m_err [2];
    int pc    [2];

    always #5 clk = ~clk;

    digit_stabilizer #(.STABLE_CNT(4), .ERR_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_digit(in_digit),
        .out_valid(ov[0]), .out_digit(od[0]), .out_seg(os[0]),
        .out_change(och[0]), .out_run(orun[0]), .out_err(oerr[0])
    );

    digit_stabilizer #(.STABLE_CNT(1), .ERR_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_digit(in_digit),
        .out_valid(ov[1]), .out_digit(od[1]), .out_seg(os[1]),
        .out_change(och[1]), .out_run(orun[1]), .out_err(oerr[1])
    );

    function automatic int stable_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
            4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
            8: return 'h7F;  9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_cand[k] = 0; m_valid[k] = 0;
            m_digit[k] = 0; m_change[k] = 0; m_err[k] = 0;
        end
    endtask

    // Run length is kept unbounded; a commit can only happen the moment it equals the threshold.
    task automatic model_step(input logic v, input int d);
        for (int k = 0; k < 2; k++) begin
            m_change[k] = 0;
            if (v) begin
                if (d > 9) begin
                    if (m_err[k] < 255) m_err[k]++;
                    m_run[k] = 0;
                end else begin
                    if (m_run[k] > 0 && d == m_cand[k]) m_run[k]++;
                    else begin m_cand[k] = d; m_run[k] = 1; end
                    if (m_run[k] == stable_of(k) && (m_valid[k] == 0 || m_cand[k] != m_digit[k])) begin
                        m_change[k] = 1;
                        m_valid[k]  = 1;
                        m_digit[k]  = m_cand[k];
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                int exp_run;
                exp_run = (m_run[k] < stable_of(k)) ? m_run[k] : stable_of(k);
                chk($sformatf("out_valid[%0d]", k),  int'(ov[k]),   m_valid[k]);
                chk($sformatf("out_digit[%0d]", k),  int'(od[k]),   m_digit[k]);
                chk($sformatf("out_seg[%0d]", k),    int'(os[k]),   m_valid[k] ? seg_of(m_digit[k]) : 0);
                chk($sformatf("out_change[%0d]", k), int'(och[k]),  m_change[k]);
                chk($sformatf("out_run[%0d]", k),    int'(orun[k]), exp_run);
                chk($sformatf("out_err[%0d]", k),    int'(oerr[k]), m_err[k]);
                if (och[k]) pc[k]++;
            end
        end
    end

    task automatic send(input logic v, input int d);
        in_valid = v;
        in_digit = 4'(d);
        @(posedge clk);
        model_step(v, d);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_rst_valid[%0d]", k), int'(ov[k]),   0);
            chk($sformatf("async_rst_seg[%0d]", k),   int'(os[k]),   0);
            chk($sformatf("async_rst_run[%0d]", k),   int'(orun[k]), 0);
            chk($sformatf("async_rst_err[%0d]", k),   int'(oerr[k]), 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int p0, p1;
        pc[0] = 0; pc[1] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_digit", int'(od[0]), 0);
        chk("reset_change", int'(och[0]), 0);
        rst = 1'b0;
        #1;

        // Four identical samples commit 5 on the first edge they complete a run.
        p0 = pc[0];
        repeat (4) send(1'b1, 5);
        chk("t2_digit", int'(od[0]), 5);
        chk("t2_seg", int'(os[0]), 'h6D);
        chk("t2_valid", int'(ov[0]), 1);
        chk("t2_run", int'(orun[0]), 4);
        send(1'b1, 5);
        chk("t2_one_pulse", pc[0] - p0, 1);

        // Interrupted run: 5,5,3,5,5,5 leaves nothing committed.
        send(1'b1, 6);
        do_reset();
        send(1'b1, 5); send(1'b1, 5); send(1'b1, 3);
        send(1'b1, 5); send(1'b1, 5); send(1'b1, 5);
        chk("t3_no_commit", int'(ov[0]), 0);
        send(1'b1, 5);
        chk("t3_commit", int'(od[0]), 5);

        // Flicker to 7 and back to 5 gives no pulse.
        p0 = pc[0];
        send(1'b1, 7); send(1'b1, 7);
        repeat (4) send(1'b1, 5);
        chk("t4_no_pulse", pc[0] - p0, 0);
        chk("t4_digit", int'(od[0]), 5);

        // Error saturation, then gaps inside a 7-run.
        repeat (300) send(1'b1, 12);
        chk("t5_err_sat", int'(oerr[0]), 255);
        chk("t5_run_zero", int'(orun[0]), 0);
        chk("t5_digit_kept", int'(od[0]), 5);
        p0 = pc[0];
        send(1'b1, 7); send(1'b0, 0); send(1'b1, 7);
        send(1'b0, 0); send(1'b0, 0); send(1'b1, 7);
        send(1'b1, 7);
        chk("t5_gap_commit", int'(od[0]), 7);
        chk("t5_gap_pulse", pc[0] - p0, 1);

        // Single-sample threshold: 2,8,8 pulses twice.
        do_reset();
        p1 = pc[1];
        send(1'b1, 2);
        chk("t6_first", int'(od[1]), 2);
        send(1'b1, 8); send(1'b1, 8);
        chk("t6_second", int'(od[1]), 8);
        chk("t6_pulses", pc[1] - p1, 2);
        send(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_digit_stabilizer
`default_nettype wire
